dmem_arbiter: RTL and testbench

//  Shares the single data-memory port between two requesters: port 0 = core load/store unit,

---
 rtl/dmem_bus_pkg.sv | 15 +
 rtl/dmem_rr_picker.sv | 72 +++++++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bus_pkg.sv
// rtl/dmem_bus_pkg.sv - shared constants for the data-memory bus and its arbiter
// Purpose : bus widths, requester port ids and the default burst limit used by
//           dmem_arbiter and dmem_rr_picker.
// Ports   : none (package).
package dmem_bus_pkg;
  localparam int DMEM_AW        = 32;
  localparam int DMEM_DW        = 32;
  localparam int DMEM_MAX_BURST = 4;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  // Burst counter; wide enough for MAX_BURST up to 15.
  typedef logic [3:0] burst_cnt_t;
endpackage

// File: rtl/dmem_rr_picker.sv
// rtl/dmem_rr_picker.sv - two-way round-robin picker with bounded burst hold
// Purpose : picks which of two requesters owns the memory port this cycle.
//           Contention alternates round-robin. A port that was already streaming
//           when its rival arrived may keep the port for up to MAX_BURST more
//           grants before it must hand over.
// Ports   : clk, rst (async, active-high)
//           req0/req1 in  : requests from port 0 / port 1
//           gnt0/gnt1 out : combinational grants, at most one high, both low in reset
module dmem_rr_picker
  import dmem_bus_pkg::*;
#(
  parameter int MAX_BURST = DMEM_MAX_BURST
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic       last_owner, last_owner_n;
  burst_cnt_t burst_cnt, burst_cnt_n;
  // Set when the last grant was uncontended or a held burst grant: only then
  // may the owner keep the port against a waiting rival.
  logic       keep_ok, keep_ok_n;

  logic both, any, keep, winner;

  always_comb begin
    both   = req0 & req1;
    any    = (req0 | req1) & ~rst;
    keep   = both & keep_ok & (burst_cnt < burst_cnt_t'(MAX_BURST));
    winner = req1;
    if (both) begin
      winner = keep ? last_owner : ~last_owner;
    end
    gnt0 = any & ~winner;
    gnt1 = any & winner;

    last_owner_n = last_owner;
    burst_cnt_n  = '0;
    keep_ok_n    = 1'b0;
    if (any) begin
      last_owner_n = winner;
      if (!both) begin
        burst_cnt_n = '0;
        keep_ok_n   = 1'b1;
      end else if (winner == last_owner) begin
        burst_cnt_n = (burst_cnt == burst_cnt_t'(MAX_BURST)) ? burst_cnt
                                                              : burst_cnt + burst_cnt_t'(1);
        keep_ok_n   = 1'b1;
      end else begin
        burst_cnt_n = burst_cnt_t'(1);
        keep_ok_n   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= PORT_DBG;
      burst_cnt  <= '0;
      keep_ok    <= 1'b0;
    end else begin
      last_owner <= last_owner_n;
      burst_cnt  <= burst_cnt_n;
      keep_ok    <= keep_ok_n;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one data-memory port between core LSU and debug master
// Purpose : arbitrates port 0 (core) and port 1 (debug/loader), drives the memory
//           port from the granted requester and routes the one-cycle read response
//           back to the port that issued it.
// Ports   : clk, rst (async, active-high)
//           mX_req/we/addr/wdata/be in : request, held until mX_gnt
//           mX_gnt out                 : request accepted this cycle (combinational)
//           mX_rvalid/mX_rdata out     : read response, cycle after a granted read
//           mem_en/we/addr/wdata/be out, mem_rdata in : memory port
//           stat_m0_grants/stat_m1_grants/stat_conflicts out : only with DMEM_ARB_STATS_EN
// Config  : DMEM_ARB_STATS_EN adds saturating grant and conflict counters.
module dmem_arbiter
  import dmem_bus_pkg::*;
#(
  parameter int AW        = DMEM_AW,
  parameter int DW        = DMEM_DW,
  parameter int MAX_BURST = DMEM_MAX_BURST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_be,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_be,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]     stat_m0_grants,
  output logic [31:0]     stat_m1_grants,
  output logic [31:0]     stat_conflicts
`endif
);

  logic [AW-1:0] addr_hold;
  logic [DW-1:0] wdata_hold;
  logic          rsp_valid;
  logic          rsp_owner;

  dmem_rr_picker #(.MAX_BURST(MAX_BURST)) u_picker (
    .clk  (clk),
    .rst  (rst),
    .req0 (m0_req),
    .req1 (m1_req),
    .gnt0 (m0_gnt),
    .gnt1 (m1_gnt)
  );

  // Address and write data hold the last granted values when idle so the
  // memory bus does not toggle needlessly.
  always_comb begin
    mem_en    = m0_gnt | m1_gnt;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = addr_hold;
    mem_wdata = wdata_hold;
    if (m0_gnt) begin
      mem_we    = m0_we;
      mem_be    = m0_be;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_we    = m1_we;
      mem_be    = m1_be;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hold  <= '0;
      wdata_hold <= '0;
      rsp_valid  <= 1'b0;
      rsp_owner  <= PORT_CORE;
    end else begin
      if (mem_en) begin
        addr_hold  <= mem_addr;
        wdata_hold <= mem_wdata;
      end
      rsp_valid <= mem_en & ~mem_we;
      if (mem_en & ~mem_we) begin
        rsp_owner <= m1_gnt;
      end
    end
  end

  always_comb begin
    m0_rvalid = rsp_valid & (rsp_owner == PORT_CORE);
    m1_rvalid = rsp_valid & (rsp_owner == PORT_DBG);
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = m1_rvalid ? mem_rdata : '0;
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_m0_grants <= '0;
      stat_m1_grants <= '0;
      stat_conflicts <= '0;
    end else begin
      if (m0_gnt && stat_m0_grants != '1) stat_m0_grants <= stat_m0_grants + 32'd1;
      if (m1_gnt && stat_m1_grants != '1) stat_m1_grants <= stat_m1_grants + 32'd1;
      if (m0_req && m1_req && stat_conflicts != '1) stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
// Purpose : drives both requester ports (directed cases, then random traffic),
//           models a word memory behind mem_*, and compares every cycle against
//           an allowance-based arbitration model and a shadow memory.
// Ports   : none (top-level bench). Stat checks compile in with DMEM_ARB_STATS_EN.
module tb_dmem_arbiter;
  localparam int MAXB = 4;

  logic        clk, rst;
  logic [1:0]  q_req, q_we;
  logic [31:0] q_addr [2];
  logic [31:0] q_wdata [2];
  logic [3:0]  q_be [2];
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_m0_grants, stat_m1_grants, stat_conflicts;
`endif

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(q_req[0]), .m0_we(q_we[0]), .m0_addr(q_addr[0]), .m0_wdata(q_wdata[0]),
    .m0_be(q_be[0]), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(q_req[1]), .m1_we(q_we[1]), .m1_addr(q_addr[1]), .m1_wdata(q_wdata[1]),
    .m1_be(q_be[1]), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_m0_grants(stat_m0_grants), .stat_m1_grants(stat_m1_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Memory behind the arbiter, driven only by the DUT's mem_* outputs.
  logic [31:0] stub_mem [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) stub_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= stub_mem[mem_addr[7:2]];
      end
    end
  end

  // Reference state: shadow memory written from requester fields, and an
  // arbitration "allowance": grants the last owner may still take while its
  // rival waits (refilled to MAXB by an uncontended grant, zeroed by a handover).
  logic [31:0] ref_mem [64];
  int          rr_last, allowance, pend_port;
  bit          pend, addr_known;
  logic [31:0] pend_data, exp_addr, exp_wdata;
  logic [1:0]  seen_gnt;
  int          gnt_log [$];
  int          exp_conf, exp_g0, exp_g1;

  task automatic model_reset();
    rr_last = 1; allowance = 0; pend = 0; pend_port = 0; addr_known = 0;
    exp_conf = 0; exp_g0 = 0; exp_g1 = 0; seen_gnt = 2'b00;
  endtask

  initial begin
    model_reset();
    forever begin : chk
      int g;
      logic [31:0] rd0, rd1;
      @(negedge clk);
      if (rst) begin
        check("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
        check("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        check("rst_rdata", {m1_rdata, m0_rdata}, 64'h0);
        check("rst_mem_ctl", {mem_en, mem_we, mem_be}, 6'h0);
        model_reset();
      end else begin
        if (q_req[0] && q_req[1]) g = (allowance > 0) ? rr_last : 1 - rr_last;
        else if (q_req[0]) g = 0;
        else if (q_req[1]) g = 1;
        else g = -1;

        check("gnt", {m1_gnt, m0_gnt}, {g == 1, g == 0});
        if (g >= 0) begin
          check("mem_ctl", {mem_en, mem_we, mem_be}, {1'b1, q_we[g], q_be[g]});
          check("mem_addr", mem_addr, q_addr[g]);
          check("mem_wdata", mem_wdata, q_wdata[g]);
        end else begin
          check("mem_idle", {mem_en, mem_we, mem_be}, 6'h0);
          if (addr_known) check("mem_hold", {mem_addr, mem_wdata}, {exp_addr, exp_wdata});
        end
        rd0 = (pend && pend_port == 0) ? pend_data : 32'h0;
        rd1 = (pend && pend_port == 1) ? pend_data : 32'h0;
        check("rvalid", {m1_rvalid, m0_rvalid}, {pend && pend_port == 1, pend && pend_port == 0});
        check("rdata0", m0_rdata, rd0);
        check("rdata1", m1_rdata, rd1);

        if (q_req[0] && q_req[1]) exp_conf++;
        pend = 0;
        seen_gnt = {g == 1, g == 0};
        if (g >= 0) begin
          if (!(q_req[0] && q_req[1])) allowance = MAXB;
          else if (g == rr_last) allowance--;
          else allowance = 0;
          rr_last = g;
          gnt_log.push_back(g);
          if (g == 0) exp_g0++; else exp_g1++;
          exp_addr = q_addr[g]; exp_wdata = q_wdata[g]; addr_known = 1;
          if (q_we[g]) begin
            for (int b = 0; b < 4; b++)
              if (q_be[g][b]) ref_mem[q_addr[g][7:2]][8*b +: 8] = q_wdata[g][8*b +: 8];
          end else begin
            pend = 1; pend_port = g; pend_data = ref_mem[q_addr[g][7:2]];
          end
        end else begin
          allowance = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 63) << 2);
  endfunction

  task automatic set_req(int p, logic we, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    q_req[p] = 1'b1; q_we[p] = we; q_addr[p] = a; q_wdata[p] = d; q_be[p] = be;
  endtask

  // Returns at posedge+1 of the cycle after the grant (read data visible now).
  task automatic wait_gnt(int p, string name, output int n);
    n = 0;
    do begin step(); n++; end while (!seen_gnt[p] && n < 50);
    check(name, seen_gnt[p], 1'b1);
    q_req[p] = 1'b0;
  endtask

  task automatic do_reset();
    q_req = 2'b00; rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, g0cnt, w1;
    bit p1done;
    for (int i = 0; i < 64; i++) begin stub_mem[i] = '0; ref_mem[i] = '0; end
    mem_rdata = '0;
    q_req = 2'b00; q_we = 2'b00;
    for (int p = 0; p < 2; p++) begin q_addr[p] = '0; q_wdata[p] = '0; q_be[p] = '0; end
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    step();

    // Port 0 SW then LW, uncontended.
    set_req(0, 1'b1, 32'h10, 32'hdeadbeef, 4'hf);
    wait_gnt(0, "sw_gnt", n);
    check("sw_latency", n, 1);
    set_req(0, 1'b0, 32'h10, 32'h0, 4'hf);
    wait_gnt(0, "lw_gnt", n);
    check("lw_rvalid", m0_rvalid, 1'b1);
    check("lw_rdata", m0_rdata, 32'hdeadbeef);
    check("lw_m1_rvalid", m1_rvalid, 1'b0);
    step();

    // Byte store from the debug port into an existing word.
    set_req(0, 1'b1, 32'h4, 32'h0000001e, 4'hf);
    wait_gnt(0, "sb_init", n);
    set_req(1, 1'b1, 32'h4, 32'h000a0000, 4'b0100);
    wait_gnt(1, "sb_gnt", n);
    set_req(1, 1'b0, 32'h4, 32'h0, 4'hf);
    wait_gnt(1, "sb_rd_gnt", n);
    check("sb_rvalid", m1_rvalid, 1'b1);
    check("sb_rdata", m1_rdata, 32'h000a001e);
    step();

    // Both ports read continuously from reset: strict alternation starting at 0.
    do_reset();
    gnt_log.delete();
    set_req(0, 1'b0, rand_addr(), 32'h0, 4'hf);
    set_req(1, 1'b0, rand_addr(), 32'h0, 4'hf);
    for (int k = 0; k < 8; k++) begin
      step();
      for (int p = 0; p < 2; p++) if (seen_gnt[p]) q_addr[p] = rand_addr();
    end
    q_req = 2'b00;
    step(); step();
    for (int i = 0; i < 8; i++) check("rr_pattern", gnt_log[i], i % 2);

    // Port 0 streams 10 reads; port 1 joins at cycle 2 and must wait <= MAXB.
    g0cnt = 0; w1 = 0; p1done = 0;
    set_req(0, 1'b0, rand_addr(), 32'h0, 4'hf);
    for (int k = 0; k < 40; k++) begin
      if (k == 2) set_req(1, 1'b0, rand_addr(), 32'h0, 4'hf);
      step();
      if (seen_gnt[0]) begin
        g0cnt++;
        if (g0cnt < 10) q_addr[0] = rand_addr(); else q_req[0] = 1'b0;
      end
      if (q_req[1]) begin
        if (seen_gnt[1]) begin p1done = 1; q_req[1] = 1'b0; end
        else w1++;
      end
    end
    check("p1_granted", p1done, 1'b1);
    check("p1_wait_bound", w1 <= MAXB, 1'b1);
    check("p0_all_reads", g0cnt, 10);

    // Reset right after a granted read: the response must vanish.
    set_req(0, 1'b0, 32'h10, 32'h0, 4'hf);
    wait_gnt(0, "pre_rst_gnt", n);
    rst = 1'b1;
    #1;
    check("rst_drops_rvalid", m0_rvalid, 1'b0);
    set_req(1, 1'b1, 32'h20, 32'h12345678, 4'hf);
    step(); step();
    q_req = 2'b00;
    rst = 1'b0;
    step(); step();

`ifdef DMEM_ARB_STATS_EN
    do_reset();
    set_req(0, 1'b0, rand_addr(), 32'h0, 4'hf);
    set_req(1, 1'b0, rand_addr(), 32'h0, 4'hf);
    for (int k = 0; k < 6; k++) step();
    q_req = 2'b00;
    step();
    check("stat_conflicts6", stat_conflicts, 32'd6);
    check("stat_grants6", stat_m0_grants + stat_m1_grants, 32'd6);
`endif

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (q_req[p] && seen_gnt[p]) begin
          q_req[p] = 1'b0;
          if ($urandom_range(0, 9) < 7)
            set_req(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(1, 15)));
        end else if (q_req[p]) begin
          if ($urandom_range(0, 99) < 3) q_req[p] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          set_req(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(1, 15)));
        end
      end
    end
    q_req = 2'b00;
    step(); step();

`ifdef DMEM_ARB_STATS_EN
    check("stat_conflicts", stat_conflicts, exp_conf);
    check("stat_m0", stat_m0_grants, exp_g0);
    check("stat_m1", stat_m1_grants, exp_g1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
